// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its IF/ID register.
package instr_fetch_pkg;

    localparam logic [31:0] NOP                = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_TRAP   = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory port, hazard/control inputs and IF/ID outputs.
interface instr_fetch_if;

    logic [31:0] o_imem_raddr;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic        i_halt;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_halted;
    logic        o_trap;

    modport master (
        output o_imem_raddr, o_instr, o_pc, o_pc_plus4, o_valid, o_halted, o_trap,
        input  i_imem_rdata, i_stall, i_redirect, i_redirect_addr, i_halt
    );

    modport slave (
        input  o_imem_raddr, o_instr, o_pc, o_pc_plus4, o_valid, o_halted, o_trap,
        output i_imem_rdata, i_stall, i_redirect, i_redirect_addr, i_halt
    );

endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: load enable, squash-to-NOP (wins over load), hold otherwise.
module instr_fetch_if_id_reg
    import instr_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   squash,
    input  if_id_t d,
    output if_id_t q,
    output logic   valid
);

    if_id_t data_d, data_q;
    logic   valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (squash) begin
            // PC fields are left alone; only the instruction and tag are killed.
            data_d.instr = NOP;
            valid_d      = 1'b0;
        end else if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '{instr: NOP, pc: 32'd0, pc_plus4: 32'd4};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, next-PC selection and RUN/HALTED/TRAP control feeding the IF/ID register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
)(
    input  logic          i_clk,
    input  logic          i_rst,
    instr_fetch_if.master bus
);

    logic [1:0]  state_d, state_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] pc_plus4;
    logic        load, squash;
    if_id_t      fetch_pkt, if_id_q;
    logic        if_id_valid;

    assign pc_plus4  = pc_q + 32'd4;
    assign fetch_pkt = '{instr: bus.i_imem_rdata, pc: pc_q, pc_plus4: pc_plus4};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        squash  = 1'b0;
        // HALTED and TRAP are sinks: nothing but reset moves them.
        if (state_q == ST_RUN) begin
            if (bus.i_redirect) begin
                squash = 1'b1;
                if (bus.i_redirect_addr[1:0] == 2'b00) begin
                    pc_d = bus.i_redirect_addr;
                end else begin
                    state_d = ST_TRAP;
                end
            end else if (bus.i_halt) begin
                squash  = 1'b1;
                state_d = ST_HALTED;
            end else if (!bus.i_stall) begin
                load = 1'b1;
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    instr_fetch_if_id_reg u_if_id (
        .clk    (i_clk),
        .rst    (i_rst),
        .load   (load),
        .squash (squash),
        .d      (fetch_pkt),
        .q      (if_id_q),
        .valid  (if_id_valid)
    );

    assign bus.o_imem_raddr = pc_q;
    assign bus.o_instr      = if_id_q.instr;
    assign bus.o_pc         = if_id_q.pc;
    assign bus.o_pc_plus4   = if_id_q.pc_plus4;
    assign bus.o_valid      = if_id_valid;
    assign bus.o_halted     = (state_q == ST_HALTED);
    assign bus.o_trap       = (state_q == ST_TRAP);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; memory word at byte address A is A>>2.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_if bus();

    instr_fetch #(.RESET_ADDR(32'h0000_0000)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_imem_rdata = bus.o_imem_raddr >> 2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_redirect_addr = 32'h0;
        bus.i_halt = 1'b0;
        step();
        step();
        chk("rst_raddr", bus.o_imem_raddr, 32'h0);
        chk("rst_instr", bus.o_instr, 32'h13);
        chk("rst_pc", bus.o_pc, 32'h0);
        chk("rst_pc4", bus.o_pc_plus4, 32'h4);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_halted", {31'd0, bus.o_halted}, 32'd0);
        chk("rst_trap", {31'd0, bus.o_trap}, 32'd0);

        // Straight-line fetch
        rst = 1'b0;
        #1;
        chk("c0_raddr", bus.o_imem_raddr, 32'h0);
        chk("c0_valid", {31'd0, bus.o_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("seq_raddr", bus.o_imem_raddr, 32'(4 * (k + 1)));
            chk("seq_instr", bus.o_instr, 32'(k));
            chk("seq_pc", bus.o_pc, 32'(4 * k));
            chk("seq_pc4", bus.o_pc_plus4, 32'(4 * k + 4));
            chk("seq_valid", {31'd0, bus.o_valid}, 32'd1);
        end

        // Stall three cycles with o_pc = 8
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", bus.o_pc, 32'h8);
            chk("stall_instr", bus.o_instr, 32'h2);
            chk("stall_raddr", bus.o_imem_raddr, 32'hC);
            chk("stall_valid", {31'd0, bus.o_valid}, 32'd1);
        end
        bus.i_stall = 1'b0;
        step();
        chk("resume_pc", bus.o_pc, 32'hC);
        chk("resume_instr", bus.o_instr, 32'h3);
        chk("resume_raddr", bus.o_imem_raddr, 32'h10);

        // Redirect to 0x100 while fetching 0x10
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'h100;
        step();
        bus.i_redirect = 1'b0;
        chk("redir_bubble_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("redir_bubble_instr", bus.o_instr, 32'h13);
        chk("redir_raddr", bus.o_imem_raddr, 32'h100);
        step();
        chk("redir_pc", bus.o_pc, 32'h100);
        chk("redir_instr", bus.o_instr, 32'h40);
        chk("redir_valid", {31'd0, bus.o_valid}, 32'd1);
        chk("redir_raddr2", bus.o_imem_raddr, 32'h104);

        // Halt with simultaneous stall at PC 0x20
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'h20;
        step();
        bus.i_redirect = 1'b0;
        chk("pre_halt_raddr", bus.o_imem_raddr, 32'h20);
        bus.i_halt = 1'b1;
        bus.i_stall = 1'b1;
        step();
        bus.i_halt = 1'b0;
        bus.i_stall = 1'b0;
        chk("halt_flag", {31'd0, bus.o_halted}, 32'd1);
        chk("halt_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("halt_instr", bus.o_instr, 32'h13);
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("halted_raddr", bus.o_imem_raddr, 32'h20);
            chk("halted_valid", {31'd0, bus.o_valid}, 32'd0);
            chk("halted_flag", {31'd0, bus.o_halted}, 32'd1);
        end
        bus.i_redirect = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("halt_rst_raddr", bus.o_imem_raddr, 32'h0);
        chk("halt_rst_flag", {31'd0, bus.o_halted}, 32'd0);
        chk("halt_rst_valid", {31'd0, bus.o_valid}, 32'd0);

        // Misaligned redirect traps
        step();
        chk("trap_pre_raddr", bus.o_imem_raddr, 32'h4);
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'h102;
        step();
        chk("trap_flag", {31'd0, bus.o_trap}, 32'd1);
        chk("trap_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("trap_raddr", bus.o_imem_raddr, 32'h4);
        bus.i_redirect_addr = 32'h200;
        step();
        bus.i_redirect = 1'b0;
        bus.i_halt = 1'b1;
        step();
        bus.i_halt = 1'b0;
        step();
        chk("trap_hold_raddr", bus.o_imem_raddr, 32'h4);
        chk("trap_hold_flag", {31'd0, bus.o_trap}, 32'd1);
        chk("trap_hold_halted", {31'd0, bus.o_halted}, 32'd0);
        chk("trap_hold_valid", {31'd0, bus.o_valid}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("trap_rst_flag", {31'd0, bus.o_trap}, 32'd0);

        // Redirect and halt together: redirect wins
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'h40;
        bus.i_halt = 1'b1;
        step();
        bus.i_redirect = 1'b0;
        bus.i_halt = 1'b0;
        chk("rh_halted", {31'd0, bus.o_halted}, 32'd0);
        chk("rh_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rh_raddr", bus.o_imem_raddr, 32'h40);
        step();
        chk("rh_pc", bus.o_pc, 32'h40);
        chk("rh_instr", bus.o_instr, 32'h10);
        chk("rh_pc4", bus.o_pc_plus4, 32'h44);
        chk("rh_valid2", {31'd0, bus.o_valid}, 32'd1);

        // PC wrap at top of address space
        bus.i_redirect = 1'b1;
        bus.i_redirect_addr = 32'hFFFF_FFFC;
        step();
        bus.i_redirect = 1'b0;
        step();
        chk("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.o_pc_plus4, 32'h0);
        chk("wrap_instr", bus.o_instr, 32'h3FFF_FFFF);
        chk("wrap_raddr", bus.o_imem_raddr, 32'h0);
        chk("wrap_trap", {31'd0, bus.o_trap}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage and IF/ID pipeline register directly upstream of the decode stage. Holds the program counter, drives the instruction-memory read address, and latches the fetched instruction and its PC into a valid-tagged IF/ID register consumed by decode. Handles stalls, control-flow redirects from execute, and halt reported by decode. Misaligned redirect targets trap.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- o_imem_raddr  out  32  instruction-memory read address (= PC register)
- i_imem_rdata  in  32  instruction word; combinational read of o_imem_raddr, same cycle
- i_stall  in  1  hold PC and IF/ID register (load-use or memory hazard)
- i_redirect  in  1  taken branch/jump resolved in execute
- i_redirect_addr  in  32  redirect target
- i_halt  in  1  decode has a valid halt instruction in IF/ID
- o_instr  out  32  IF/ID instruction; NOP (32'h0000_0013) when not valid
- o_pc  out  32  IF/ID PC of o_instr
- o_pc_plus4  out  32  o_pc + 4 (registered with o_pc)
- o_valid  out  1  IF/ID holds a real instruction
- o_halted  out  1  fetch stopped by halt
- o_trap  out  1  fetch stopped by misaligned redirect target

## Operation
- States: RUN, HALTED, TRAP. Reset -> RUN.
- Reset values: PC = RESET_ADDR, o_instr = NOP, o_pc = 0, o_pc_plus4 = 4, o_valid = 0, o_halted = 0, o_trap = 0.
- RUN, per cycle, priority high to low:
  - i_redirect, target[1:0] == 0: PC <= target; IF/ID <= NOP, o_valid <= 0 (squash wrong-path fetch). Overrides i_stall and i_halt (halt is on wrong path).
  - i_redirect, target[1:0] != 0: -> TRAP; PC unchanged; IF/ID <= NOP, valid 0; o_trap <= 1.
  - i_halt: -> HALTED; PC unchanged; IF/ID <= NOP, valid 0 (no instruction after halt reaches decode); o_halted <= 1. Overrides i_stall.
  - i_stall: PC and IF/ID unchanged.
  - else: IF/ID <= {i_imem_rdata, PC, PC+4}, o_valid <= 1; PC <= PC + 4.
- HALTED, TRAP: all inputs except i_rst ignored; PC, IF/ID, flags frozen. Exit only via i_rst.
- Arithmetic: PC + 4 modulo 2^32; PC 32'hFFFF_FFFC wraps to 0 with no flag.
- PC[1:0] always 00 by construction.

## Timing
- Fetch latency: instruction at address A appears on o_instr one cycle after o_imem_raddr = A.
- After reset deassert: cycle 0 o_imem_raddr = RESET_ADDR, o_valid = 0; cycle 1 o_valid = 1 with instruction at RESET_ADDR.
- Redirect penalty: one bubble in IF/ID; target instruction valid two edges after i_redirect sampled.
- Halt: o_halted rises on edge that samples i_halt; o_valid low same edge.
- Stall: any length; exact IF/ID contents retained, no instruction lost or duplicated.
- i_rst mid-operation (any state) restores reset values on next edge, overriding all inputs.

## Structure
- Shared package: NOP encoding 32'h0000_0013, state enum {RUN, HALTED, TRAP}, default RESET_ADDR.
- One sub-module natural: if_id_reg (IF/ID register with load enable and squash-to-NOP); PC, next-PC mux and FSM in top.

## Test plan
- Reset with RESET_ADDR = 0, memory word[k] = k: o_imem_raddr sequence 0,4,8,12; o_instr 0,1,2 with o_pc 0,4,8 and o_valid 1 from cycle 1.
- Stall 3 cycles while o_pc = 8: o_pc, o_instr, o_imem_raddr held for 3 cycles, then resumes with o_pc = 12; no skip or repeat.
- i_redirect to 0x100 while fetching 0x10: next o_valid = 0; following cycle o_pc = 0x100, o_valid = 1; address 0x10 never valid.
- i_halt with simultaneous i_stall at PC 0x20: o_halted = 1, o_valid = 0, o_imem_raddr frozen at 0x20 for 10+ cycles; i_rst returns to RESET_ADDR, o_halted = 0.
- i_redirect to 0x102: o_trap = 1, o_valid = 0, PC frozen; later redirect/halt ignored until reset.
- i_redirect and i_halt same cycle to 0x40: no halt; o_pc = 0x40 valid two edges later.
